instr_encoder_loader: RTL and testbench

Sequential RV32I instruction encoder and loader: accepts one decoded instruction description per handshake (format, opcode, register fields, funct fields, immediate) and packs it into a 32-bit RV32I word. It writes consecutive words into instruction memory through a write/ack port. It is the encoder-side counterpart of the control decoder and sits between the testbench or boot host and instruction memory. It fills the program image before the core is released from reset, and stops on a HALT entry or when memory is full.

---
 rtl/rv32i_enc_pkg.sv | 42 ++++
 rtl/instr_pack.sv | 57 +++++
 rtl/instr_encoder_loader.sv | 144 ++++++++++++++
 tb/tb_instr_encoder_loader.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_enc_pkg.sv
// Shared RV32I encoder definitions: instruction formats, opcodes and the HALT word.
// Also used by the control decoder, so opcode names stay in step on both sides.
package rv32i_enc_pkg;

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_HALT = 3'd6,
        FMT_RSVD = 3'd7
    } fmt_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } ld_state_e;

    localparam logic [6:0] R_TYPE = 7'b0110011;
    localparam logic [6:0] I_TYPE = 7'b0010011;
    localparam logic [6:0] LW     = 7'b0000011;
    localparam logic [6:0] SW     = 7'b0100011;
    localparam logic [6:0] BR     = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] HALT   = 7'b1111111;

    localparam logic [31:0] HALT_WORD = 32'h0000_007F;

    // True when v is the sign extension of its low 'bits' bits.
    function automatic logic fits_signed(logic [31:0] v, int bits);
        logic [31:0] hi;
        hi = $signed(v) >>> (bits - 1);
        return (hi == '0) || (hi == '1);
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I word packer for one decoded instruction description.
// Define IMM_RANGE_CHECK_EN to flag immediates that do not fit their format.
module instr_pack
    import rv32i_enc_pkg::*;
(
    input  logic [2:0]  fmt_i,
    input  logic [6:0]  opcode_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  logic [31:0] imm_i,
    output logic [31:0] word_o,
    output logic        halt_o,
    output logic        viol_o
);

    logic isShift;
    assign isShift = (opcode_i == I_TYPE) && ((funct3_i == 3'b001) || (funct3_i == 3'b101));

    always_comb begin
        word_o = HALT_WORD;
        halt_o = 1'b0;
        case (fmt_i)
            FMT_R: word_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
            // Shift-immediates carry funct7 in the upper immediate bits.
            FMT_I: word_o = isShift ? {funct7_i, imm_i[4:0], rs1_i, funct3_i, rd_i, opcode_i}
                                    : {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
            FMT_S: word_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
            FMT_B: word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                             imm_i[4:1], imm_i[11], opcode_i};
            FMT_U: word_o = {imm_i[31:12], rd_i, opcode_i};
            FMT_J: word_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
            default: begin
                word_o = HALT_WORD;
                halt_o = 1'b1;
            end
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    always_comb begin
        viol_o = 1'b0;
        case (fmt_i)
            FMT_I, FMT_S: viol_o = !fits_signed(imm_i, 12);
            FMT_B:        viol_o = !fits_signed(imm_i, 13) || imm_i[0];
            FMT_J:        viol_o = !fits_signed(imm_i, 21) || imm_i[0];
            FMT_U:        viol_o = (imm_i[11:0] != 12'd0);
            default:      viol_o = 1'b0;
        endcase
    end
`else
    assign viol_o = 1'b0;
`endif

endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes one instruction per handshake and writes it to instruction memory.
// Stops on HALT or a full memory; IMM_RANGE_CHECK_EN enables the immediate error path.
module instr_encoder_loader
    import rv32i_enc_pkg::*;
#(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_fmt,
    input  logic [6:0]        req_opcode,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [2:0]        req_funct3,
    input  logic [6:0]        req_funct7,
    input  logic [31:0]       req_imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic              restart,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W:0] LAST = {1'b0, {ADDR_W{1'b1}}};

    ld_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              halt_q, halt_d;

    logic [31:0] packWord;
    logic        packHalt;
    logic        packViol;

    instr_pack u_pack (
        .fmt_i    (req_fmt),
        .opcode_i (req_opcode),
        .rd_i     (req_rd),
        .rs1_i    (req_rs1),
        .rs2_i    (req_rs2),
        .funct3_i (req_funct3),
        .funct7_i (req_funct7),
        .imm_i    (req_imm),
        .word_o   (packWord),
        .halt_o   (packHalt),
        .viol_o   (packViol)
    );

    logic lastWord;
    assign lastWord = (count_q == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            count_q <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            done_q  <= done_d;
            err_q   <= err_d;
            halt_q  <= halt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (req_valid) state_d = packViol ? ST_DONE : ST_WRITE;
            ST_WRITE: if (mem_ack) state_d = (halt_q || lastWord) ? ST_DONE : ST_IDLE;
            ST_DONE:  if (restart) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath register updates mirror the transitions chosen above.
    always_comb begin
        req_ready = (state_q == ST_IDLE);
        addr_d    = addr_q;
        count_d   = count_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        done_d    = done_q;
        err_d     = err_q;
        halt_d    = halt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (packViol) begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        wdata_d = packWord;
                        halt_d  = packHalt;
                        we_d    = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                if (mem_ack) begin
                    we_d    = 1'b0;
                    addr_d  = addr_q + ADDR_W'(1);
                    count_d = count_q + (ADDR_W+1)'(1);
                    done_d  = halt_q || lastWord;
                end
            end
            ST_DONE: begin
                if (restart) begin
                    addr_d  = '0;
                    count_d = '0;
                    err_d   = 1'b0;
                    done_d  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign done      = done_q;
    assign err       = err_q;
    assign count     = count_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: directed program load plus random traffic
// compared every cycle against a transaction-level model of the loader.
module tb_instr_encoder_loader;

    localparam int AW  = 4;
    localparam int CAP = 1 << AW;
`ifdef IMM_RANGE_CHECK_EN
    localparam bit RANGE_ON = 1'b1;
`else
    localparam bit RANGE_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [2:0]    req_fmt;
    logic [6:0]    req_opcode;
    logic [4:0]    req_rd, req_rs1, req_rs2;
    logic [2:0]    req_funct3;
    logic [6:0]    req_funct7;
    logic [31:0]   req_imm;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_ack;
    logic          restart;
    logic          done;
    logic          err;
    logic [AW:0]   count;

    int checks = 0;
    int fails  = 0;

    instr_encoder_loader #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_fmt    (req_fmt),
        .req_opcode (req_opcode),
        .req_rd     (req_rd),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .req_funct3 (req_funct3),
        .req_funct7 (req_funct7),
        .req_imm    (req_imm),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .restart    (restart),
        .done       (done),
        .err        (err),
        .count      (count)
    );

    always #5 clk = ~clk;

    // Reference encoding built from field positions with shifts and masks.
    function automatic logic [31:0] encWord(logic [2:0] fmt, logic [31:0] op, logic [31:0] rd,
                                            logic [31:0] rs1, logic [31:0] rs2, logic [31:0] f3,
                                            logic [31:0] f7, logic [31:0] imm);
        logic [31:0] hi12;
        case (fmt)
            3'd0: return (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
            3'd1: begin
                hi12 = imm & 32'hFFF;
                if (op == 32'h13 && (f3 == 1 || f3 == 5)) hi12 = (f7 << 5) | (imm & 32'h1F);
                return (hi12 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
            end
            3'd2: return (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
                         | ((imm & 32'h1F) << 7) | op;
            3'd3: return (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20)
                         | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 32'hF) << 8)
                         | (((imm >> 11) & 1) << 7) | op;
            3'd4: return (imm & 32'hFFFFF000) | (rd << 7) | op;
            3'd5: return (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                         | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12)
                         | (rd << 7) | op;
            default: return 32'h0000007F;
        endcase
    endfunction

    function automatic bit immBad(logic [2:0] fmt, logic [31:0] imm);
        int s;
        s = imm;
        case (fmt)
            3'd1, 3'd2: return (s < -2048) || (s > 2047);
            3'd3:       return (s < -4096) || (s > 4095) || imm[0];
            3'd4:       return (imm & 32'hFFF) != 0;
            3'd5:       return (s < -(1 << 20)) || (s > (1 << 20) - 1) || imm[0];
            default:    return 1'b0;
        endcase
    endfunction

    task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: a pending write, a finished load, the error flag and the words written.
    bit          mPend, mFin, mErr, mHalt;
    int          mCount;
    logic [31:0] mWord;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mPend  <= 1'b0;
            mFin   <= 1'b0;
            mErr   <= 1'b0;
            mHalt  <= 1'b0;
            mCount <= 0;
            mWord  <= '0;
        end else if (mPend) begin
            if (mem_ack) begin
                mPend  <= 1'b0;
                mCount <= mCount + 1;
                if (mHalt || mCount + 1 == CAP) mFin <= 1'b1;
            end
        end else if (mFin) begin
            if (restart) begin
                mFin   <= 1'b0;
                mCount <= 0;
                mErr   <= 1'b0;
            end
        end else if (req_valid) begin
            if (RANGE_ON && immBad(req_fmt, req_imm)) begin
                mErr <= 1'b1;
                mFin <= 1'b1;
            end else begin
                mWord <= encWord(req_fmt, 32'(req_opcode), 32'(req_rd), 32'(req_rs1),
                                 32'(req_rs2), 32'(req_funct3), 32'(req_funct7), req_imm);
                mHalt <= (req_fmt >= 3'd6);
                mPend <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        checkOutput("m_ready", 32'(req_ready), 32'(!mPend && !mFin));
        checkOutput("m_we",    32'(mem_we),    32'(mPend));
        checkOutput("m_done",  32'(done),      32'(mFin));
        checkOutput("m_err",   32'(err),       32'(mErr));
        checkOutput("m_count", 32'(count),     32'(mCount));
        checkOutput("m_addr",  32'(mem_addr),  32'(mCount % CAP));
        if (mPend) checkOutput("m_wdata", mem_wdata, mWord);
    end

    task automatic setReq(logic [2:0] fmt, logic [6:0] op, logic [4:0] rd, logic [4:0] rs1,
                          logic [4:0] rs2, logic [2:0] f3, logic [6:0] f7, logic [31:0] imm);
        req_fmt    = fmt;
        req_opcode = op;
        req_rd     = rd;
        req_rs1    = rs1;
        req_rs2    = rs2;
        req_funct3 = f3;
        req_funct7 = f7;
        req_imm    = imm;
    endtask

    // Starts at posedge+2; ends at posedge+2 just after the acknowledging edge.
    task automatic applyStimulus(int ackDelay, logic [31:0] expWord, int expAddr);
        req_valid = 1'b1;
        mem_ack   = 1'b0;
        @(posedge clk); #2;
        req_valid = 1'b0;
        for (int i = 0; i <= ackDelay; i++) begin
            if (i == ackDelay) mem_ack = 1'b1;
            @(negedge clk);
            checkOutput("wr_we",    32'(mem_we),    32'd1);
            checkOutput("wr_wdata", mem_wdata,      expWord);
            checkOutput("wr_addr",  32'(mem_addr),  32'(expAddr));
            checkOutput("wr_ready", 32'(req_ready), 32'd0);
            @(posedge clk); #2;
        end
        mem_ack = 1'b0;
    endtask

    task automatic pulseRestart();
        restart = 1'b1;
        @(posedge clk); #2;
        restart = 1'b0;
    endtask

    function automatic logic [31:0] randImm();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 8191)) - 32'd4096;
            1:       return $urandom;
            2:       return $urandom & 32'hFFFFF000;
            default: return (32'($urandom_range(0, 4095)) - 32'd2048) << 1;
        endcase
    endfunction

    initial begin
        reset = 1'b1;
        req_valid = 1'b0;
        mem_ack = 1'b0;
        restart = 1'b0;
        setReq(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;

        @(negedge clk);
        checkOutput("rst_ready", 32'(req_ready), 32'd1);
        checkOutput("rst_we",    32'(mem_we),    32'd0);
        checkOutput("rst_done",  32'(done),      32'd0);
        checkOutput("rst_err",   32'(err),       32'd0);
        checkOutput("rst_addr",  32'(mem_addr),  32'd0);
        checkOutput("rst_wdata", mem_wdata,      32'd0);
        checkOutput("rst_count", 32'(count),     32'd0);
        @(posedge clk); #2;

        setReq(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        applyStimulus(0, 32'h00500093, 0);
        setReq(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        applyStimulus(0, 32'h002081B3, 1);
        setReq(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
        applyStimulus(3, 32'h0020A423, 2);
        setReq(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8);
        applyStimulus(0, 32'h00208463, 3);
        setReq(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd16);
        applyStimulus(1, 32'h010000EF, 4);
        setReq(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
        applyStimulus(0, 32'h123452B7, 5);
        checkOutput("count6", 32'(count), 32'd6);

        setReq(3'd6, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        applyStimulus(0, 32'h0000007F, 6);
        checkOutput("halt_done",  32'(done),      32'd1);
        checkOutput("halt_ready", 32'(req_ready), 32'd0);
        pulseRestart();
        checkOutput("rs_count", 32'(count),     32'd0);
        checkOutput("rs_ready", 32'(req_ready), 32'd1);

        setReq(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        applyStimulus(0, 32'h00500093, 0);
        applyStimulus(2, 32'h00500093, 1);
        setReq(3'd7, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        applyStimulus(0, 32'h0000007F, 2);
        checkOutput("halt2_done", 32'(done), 32'd1);
        setReq(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        req_valid = 1'b1;
        repeat (2) @(posedge clk);
        #2 req_valid = 1'b0;
        checkOutput("ignored_count", 32'(count),  32'd3);
        checkOutput("ignored_we",    32'(mem_we), 32'd0);
        pulseRestart();

        for (int i = 0; i < CAP; i++) applyStimulus(0, 32'h00500093, i);
        checkOutput("full_done",  32'(done),  32'd1);
        checkOutput("full_count", 32'(count), 32'(CAP));
        req_valid = 1'b1;
        repeat (3) @(posedge clk);
        #2 req_valid = 1'b0;
        checkOutput("full_we",    32'(mem_we),    32'd0);
        checkOutput("full_ready", 32'(req_ready), 32'd0);
        pulseRestart();
        checkOutput("full_rs_count", 32'(count), 32'd0);

        setReq(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096);
`ifdef IMM_RANGE_CHECK_EN
        req_valid = 1'b1;
        @(posedge clk); #2;
        req_valid = 1'b0;
        checkOutput("rng_we",   32'(mem_we), 32'd0);
        checkOutput("rng_err",  32'(err),    32'd1);
        checkOutput("rng_done", 32'(done),   32'd1);
        pulseRestart();
        checkOutput("rng_err_clr", 32'(err), 32'd0);
`else
        applyStimulus(0, 32'h00000093, 0);
        checkOutput("trunc_err", 32'(err), 32'd0);
`endif

        setReq(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        req_valid = 1'b1;
        @(posedge clk); #2;
        req_valid = 1'b0;
        reset = 1'b1;
        #1;
        checkOutput("arst_we",    32'(mem_we),    32'd0);
        checkOutput("arst_wdata", mem_wdata,      32'd0);
        checkOutput("arst_addr",  32'(mem_addr),  32'd0);
        checkOutput("arst_count", 32'(count),     32'd0);
        checkOutput("arst_done",  32'(done),      32'd0);
        checkOutput("arst_err",   32'(err),       32'd0);
        checkOutput("arst_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #2;
        reset = 1'b0;

        for (int c = 0; c < 4000; c++) begin
            reset     = ($urandom_range(0, 599) == 0);
            req_valid = ($urandom_range(0, 9) < 7);
            setReq(($urandom_range(0, 15) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5)),
                   $urandom_range(0, 1) ? 7'h13 : 7'($urandom),
                   5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom),
                   randImm());
            mem_ack = ($urandom_range(0, 9) < 6);
            restart = ($urandom_range(0, 3) == 0);
            @(posedge clk); #2;
        end
        reset = 1'b0;
        req_valid = 1'b0;
        mem_ack = 1'b0;
        restart = 1'b0;
        repeat (3) @(posedge clk);
        #2;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
